// File: rtl/fetch_queue_unit_if.sv
// Fetch unit bus bundle: redirect input, imem request/response channels and decode output.
//   master : fetch unit side (drives imem request and decode output)
//   slave  : environment side (drives redirect, imem response and decode ready)
interface fetch_queue_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_resp_valid;
   logic [31:0]     imem_resp_data;
   logic            imem_resp_err;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [31:0]     out_instr;
   logic [1:0]      out_fault;

   modport master (
      input  redirect_valid, redirect_pc,
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready,
      input  imem_resp_valid, imem_resp_data, imem_resp_err,
      output out_valid, out_pc, out_instr, out_fault,
      input  out_ready
   );

   modport slave (
      output redirect_valid, redirect_pc,
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready,
      output imem_resp_valid, imem_resp_data, imem_resp_err,
      input  out_valid, out_pc, out_instr, out_fault,
      output out_ready
   );
endinterface

// File: rtl/fetch_queue_unit.sv
// Fetch stage: owns the fetch PC, issues pipelined imem requests, buffers returned words in an
// instruction queue toward decode, and handles a merged redirect that flushes the queue and
// discards in-flight responses.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fetch_queue_unit_if.master (redirect, imem req/resp, decode output)
module fetch_queue_unit #(
   parameter int unsigned     XLEN            = 32,
   parameter logic [XLEN-1:0] RESET_PC        = '0,
   parameter int unsigned     QDEPTH          = 4,
   parameter int unsigned     MAX_OUTSTANDING = 2
) (
   input logic                clk,
   input logic                reset,
   fetch_queue_unit_if.master bus
);
   localparam int unsigned CW = $clog2(QDEPTH + 1);
   localparam int unsigned QW = $clog2(QDEPTH);
   localparam int unsigned TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
      logic [1:0]      fault;
   } entry_t;

   state_t          r_state, w_state_nxt;
   logic [XLEN-1:0] r_pc;
   logic [CW-1:0]   r_inflight, r_drop, r_count;
   logic [QW-1:0]   r_wptr, r_rptr;
   entry_t          r_q [QDEPTH];
   logic [XLEN-1:0] r_tag [MAX_OUTSTANDING];
   logic [TW-1:0]   r_tag_wptr, r_tag_rptr;

   logic            w_req_valid, w_req_fire, w_resp, w_stale;
   logic            w_redir, w_redir_bad, w_resp_push, w_push, w_pop;
   logic [CW-1:0]   w_inflight_nxt;
   logic [QW-1:0]   w_push_idx;
   entry_t          w_push_entry;

   function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
      return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + TW'(1);
   endfunction

   // Handshake qualifiers
   always_comb begin
      w_req_fire     = w_req_valid & bus.imem_req_ready;
      w_resp         = bus.imem_resp_valid;
      w_stale        = (r_drop != '0);
      w_redir        = bus.redirect_valid;
      w_redir_bad    = w_redir & (bus.redirect_pc[1:0] != 2'b00);
      // Responses are only queued in RUN; after an access fault the rest are discarded
      w_resp_push    = w_resp & ~w_stale & (r_state == ST_RUN) & ~w_redir;
      w_push         = w_resp_push | w_redir_bad;
      w_pop          = (r_count != '0) & bus.out_ready & ~w_redir;
      w_inflight_nxt = r_inflight + CW'(w_req_fire) - CW'(w_resp);
      w_push_idx     = w_redir ? '0 : r_wptr;
   end

   // Entry written into the queue this cycle
   always_comb begin
      w_push_entry = '{pc: r_tag[r_tag_rptr], instr: bus.imem_resp_data, fault: 2'b00};
      if (w_redir_bad) begin
         w_push_entry = '{pc: bus.redirect_pc, instr: NOP_INSTR, fault: 2'b10};
      end else if (bus.imem_resp_err) begin
         w_push_entry.instr = NOP_INSTR;
         w_push_entry.fault = 2'b01;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_RUN;
      else       r_state <= w_state_nxt;
   end

   // FSM next state
   always_comb begin
      w_state_nxt = r_state;
      if (w_redir)                                w_state_nxt = w_redir_bad ? ST_HALT : ST_RUN;
      else if (w_resp_push && bus.imem_resp_err)  w_state_nxt = ST_HALT;
   end

   // FSM outputs; request issue reserves queue space for every in-flight word
   always_comb begin
      w_req_valid = ~reset & (r_state == ST_RUN)
                  & (r_inflight < CW'(MAX_OUTSTANDING))
                  & (({1'b0, r_count} + {1'b0, r_inflight}) < (CW + 1)'(QDEPTH));
      bus.imem_req_valid = w_req_valid;
      bus.imem_req_addr  = r_pc;
      bus.out_valid      = (r_count != '0);
      bus.out_pc         = r_q[r_rptr].pc;
      bus.out_instr      = r_q[r_rptr].instr;
      bus.out_fault      = (r_count != '0) ? r_q[r_rptr].fault : 2'b00;
   end

   // Queue and tag storage (no reset needed; guarded by counters)
   always_ff @(posedge clk) begin
      if (!reset && w_req_fire) r_tag[r_tag_wptr]  <= r_pc;
      if (!reset && w_push)     r_q[w_push_idx]    <= w_push_entry;
   end

   // PC, counters and pointers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc       <= RESET_PC;
         r_inflight <= '0;
         r_drop     <= '0;
         r_count    <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_tag_wptr <= '0;
         r_tag_rptr <= '0;
      end else begin
         if (w_req_fire) r_tag_wptr <= tag_inc(r_tag_wptr);
         if (w_resp)     r_tag_rptr <= tag_inc(r_tag_rptr);
         r_inflight <= w_inflight_nxt;
         if (w_redir) begin
            // Everything still outstanding after this edge belongs to the old stream
            r_drop <= w_inflight_nxt;
            r_rptr <= '0;
            if (w_redir_bad) begin
               r_wptr  <= QW'(1);
               r_count <= CW'(1);
            end else begin
               r_pc    <= bus.redirect_pc;
               r_wptr  <= '0;
               r_count <= '0;
            end
         end else begin
            if (w_req_fire)        r_pc   <= r_pc + XLEN'(4);
            if (w_resp && w_stale) r_drop <= r_drop - CW'(1);
            if (w_push)            r_wptr <= r_wptr + QW'(1);
            if (w_pop)             r_rptr <= r_rptr + QW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
         end
      end
   end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Testbench for fetch_queue_unit: in-order memory model with configurable latency and a
// scoreboard of expected decode entries, plus directed checks per scenario.
module tb_fetch_queue_unit;
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [1:0]  fault;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
      bit          stale;
   } mreq_t;

   logic clk, rst0, rstw;
   logic tb_sel;
   logic tb_redir, tb_req_ready, tb_resp_valid, tb_resp_err, tb_out_ready;
   logic [31:0] tb_redir_pc, tb_resp_data;

   logic        m_req_valid, m_out_valid;
   logic [31:0] m_req_addr, m_out_pc, m_out_instr;
   logic [1:0]  m_out_fault;

   exp_t  exp_q [$];
   mreq_t mq [$];
   int    n_cmp, n_err;
   int    cyc, lat, fires, pops;
   logic  model_halted;
   logic [31:0] exp_pc, err_addr;

   fetch_queue_unit_if #(.XLEN(32)) b0 ();
   fetch_queue_unit_if #(.XLEN(32)) bw ();

   fetch_queue_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .QDEPTH(4), .MAX_OUTSTANDING(2))
      u_dut0 (.clk(clk), .reset(rst0), .bus(b0));
   fetch_queue_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .QDEPTH(4), .MAX_OUTSTANDING(2))
      u_dutw (.clk(clk), .reset(rstw), .bus(bw));

   assign b0.redirect_valid  = tb_redir;
   assign b0.redirect_pc     = tb_redir_pc;
   assign b0.imem_req_ready  = tb_req_ready;
   assign b0.imem_resp_valid = tb_resp_valid;
   assign b0.imem_resp_data  = tb_resp_data;
   assign b0.imem_resp_err   = tb_resp_err;
   assign b0.out_ready       = tb_out_ready;
   assign bw.redirect_valid  = tb_redir;
   assign bw.redirect_pc     = tb_redir_pc;
   assign bw.imem_req_ready  = tb_req_ready;
   assign bw.imem_resp_valid = tb_resp_valid;
   assign bw.imem_resp_data  = tb_resp_data;
   assign bw.imem_resp_err   = tb_resp_err;
   assign bw.out_ready       = tb_out_ready;

   assign m_req_valid = tb_sel ? bw.imem_req_valid : b0.imem_req_valid;
   assign m_req_addr  = tb_sel ? bw.imem_req_addr  : b0.imem_req_addr;
   assign m_out_valid = tb_sel ? bw.out_valid      : b0.out_valid;
   assign m_out_pc    = tb_sel ? bw.out_pc         : b0.out_pc;
   assign m_out_instr = tb_sel ? bw.out_instr      : b0.out_instr;
   assign m_out_fault = tb_sel ? bw.out_fault      : b0.out_fault;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0003;
   endfunction

   task automatic model_clear(input logic [31:0] start_pc);
      mq.delete();
      exp_q.delete();
      model_halted = 1'b0;
      exp_pc       = start_pc;
      err_addr     = 32'hFFFF_FFFF;
      cyc = 0; fires = 0; pops = 0;
   endtask

   // One clock cycle: drive inputs at negedge, check/predict, advance to the next negedge
   task automatic cycle(input logic redir, input logic [31:0] rpc);
      logic  resp_v;
      mreq_t r;
      exp_t  e;
      resp_v = 1'b0;
      r = '{addr: 32'h0, due: 0, stale: 1'b0};
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         resp_v = 1'b1;
         r = mq.pop_front();
      end
      tb_resp_valid = resp_v;
      tb_resp_data  = resp_v ? mem_word(r.addr) : 32'h0;
      tb_resp_err   = resp_v && (r.addr == err_addr);
      tb_redir      = redir;
      tb_redir_pc   = rpc;
      #1;
      if (model_halted) begin
         n_cmp++;
         if (m_req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL halted_req cyc=%0d: req_valid got %b want 0", cyc, m_req_valid);
         end
      end
      if (m_req_valid && tb_req_ready) begin
         n_cmp++;
         if (m_req_addr !== exp_pc) begin
            n_err++;
            $display("FAIL req_addr cyc=%0d: got %h want %h", cyc, m_req_addr, exp_pc);
         end
         mq.push_back('{addr: m_req_addr, due: cyc + lat, stale: redir});
         exp_pc = exp_pc + 32'd4;
         fires++;
      end
      if (m_out_valid && tb_out_ready && !redir) begin
         n_cmp++;
         pops++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL out_unexpected cyc=%0d: got pc %h with nothing expected", cyc, m_out_pc);
         end else begin
            e = exp_q.pop_front();
            if (m_out_pc !== e.pc || m_out_instr !== e.instr || m_out_fault !== e.fault) begin
               n_err++;
               $display("FAIL out_entry cyc=%0d: got pc %h instr %h fault %b want pc %h instr %h fault %b",
                        cyc, m_out_pc, m_out_instr, m_out_fault, e.pc, e.instr, e.fault);
            end
         end
      end
      if (resp_v && !r.stale && !redir && !model_halted) begin
         if (tb_resp_err) begin
            exp_q.push_back('{pc: r.addr, instr: 32'h0000_0013, fault: 2'b01});
            model_halted = 1'b1;
         end else begin
            exp_q.push_back('{pc: r.addr, instr: mem_word(r.addr), fault: 2'b00});
         end
      end
      if (redir) begin
         foreach (mq[i]) mq[i].stale = 1'b1;
         exp_q.delete();
         if (rpc[1:0] == 2'b00) begin
            exp_pc       = rpc;
            model_halted = 1'b0;
         end else begin
            exp_q.push_back('{pc: rpc, instr: 32'h0000_0013, fault: 2'b10});
            model_halted = 1'b1;
         end
      end
      @(negedge clk);
      tb_redir      = 1'b0;
      tb_resp_valid = 1'b0;
      cyc++;
   endtask

   task automatic do_reset(input logic sel_w);
      tb_sel = sel_w;
      rst0 = 1'b1; rstw = 1'b1;
      tb_redir = 1'b0; tb_resp_valid = 1'b0; tb_resp_err = 1'b0;
      repeat (2) @(negedge clk);
      model_clear(sel_w ? 32'hFFFF_FFF8 : 32'h0);
      if (sel_w) rstw = 1'b0;
      else       rst0 = 1'b0;
   endtask

   // Wait (bounded) until the head is valid, then check its PC
   task automatic expect_head_pc(input string name, input logic [31:0] want);
      for (int i = 0; i < 20 && !m_out_valid; i++) cycle(1'b0, 32'h0);
      n_cmp++;
      if (m_out_valid !== 1'b1 || m_out_pc !== want) begin
         n_err++;
         $display("FAIL %s: got valid %b pc %h want valid 1 pc %h", name, m_out_valid, m_out_pc, want);
      end
   endtask

   task automatic test_reset();
      tb_sel = 1'b0; rst0 = 1'b1; rstw = 1'b1;
      tb_resp_valid = 1'b0; tb_resp_err = 1'b0; tb_out_ready = 1'b1;
      tb_redir = 1'b1; tb_redir_pc = 32'h0000_0300;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         n_cmp++;
         if (m_req_valid !== 1'b0 || m_out_valid !== 1'b0 || m_out_fault !== 2'b00) begin
            n_err++;
            $display("FAIL reset_outputs: got req_valid %b out_valid %b fault %b want 0 0 00",
                     m_req_valid, m_out_valid, m_out_fault);
         end
      end
      @(negedge clk);
      tb_redir = 1'b0;
      model_clear(32'h0);
      rst0 = 1'b0;
      #1;
      n_cmp++;
      if (m_req_valid !== 1'b1 || m_req_addr !== 32'h0) begin
         n_err++;
         $display("FAIL first_req: got valid %b addr %h want 1 00000000", m_req_valid, m_req_addr);
      end
      lat = 1;
      repeat (4) cycle(1'b0, 32'h0);
   endtask

   task automatic test_back_to_back();
      do_reset(1'b0);
      lat = 1; tb_out_ready = 1'b1;
      repeat (12) cycle(1'b0, 32'h0);
      n_cmp++;
      if (fires != 12 || pops != 10) begin
         n_err++;
         $display("FAIL throughput: got fires %0d pops %0d want 12 10", fires, pops);
      end
   endtask

   task automatic test_backpressure();
      do_reset(1'b0);
      lat = 1; tb_out_ready = 1'b0;
      repeat (10) cycle(1'b0, 32'h0);
      n_cmp++;
      if (fires != 4 || m_req_valid !== 1'b0) begin
         n_err++;
         $display("FAIL full_queue: got fires %0d req_valid %b want 4 0", fires, m_req_valid);
      end
      repeat (3) cycle(1'b0, 32'h0);
      n_cmp++;
      if (m_out_valid !== 1'b1 || m_out_pc !== 32'h0 || m_out_instr !== mem_word(32'h0)) begin
         n_err++;
         $display("FAIL head_stable: got valid %b pc %h instr %h want 1 00000000 %h",
                  m_out_valid, m_out_pc, m_out_instr, mem_word(32'h0));
      end
      tb_out_ready = 1'b1;
      repeat (8) cycle(1'b0, 32'h0);
   endtask

   task automatic test_redirect_inflight();
      do_reset(1'b0);
      lat = 3; tb_out_ready = 1'b1;
      repeat (2) cycle(1'b0, 32'h0);
      n_cmp++;
      if (m_req_valid !== 1'b0) begin
         n_err++;
         $display("FAIL max_outstanding: got req_valid %b want 0", m_req_valid);
      end
      cycle(1'b1, 32'h0000_0100);
      expect_head_pc("redirect_head", 32'h0000_0100);
      repeat (10) cycle(1'b0, 32'h0);
   endtask

   task automatic test_misaligned();
      do_reset(1'b0);
      lat = 1; tb_out_ready = 1'b1;
      repeat (4) cycle(1'b0, 32'h0);
      tb_out_ready = 1'b0;
      cycle(1'b1, 32'h0000_0102);
      n_cmp++;
      if (m_out_valid !== 1'b1 || m_out_pc !== 32'h0000_0102 ||
          m_out_instr !== 32'h0000_0013 || m_out_fault !== 2'b10) begin
         n_err++;
         $display("FAIL misaligned_entry: got valid %b pc %h instr %h fault %b want 1 00000102 00000013 10",
                  m_out_valid, m_out_pc, m_out_instr, m_out_fault);
      end
      repeat (6) cycle(1'b0, 32'h0);
      tb_out_ready = 1'b1;
      repeat (2) cycle(1'b0, 32'h0);
      cycle(1'b1, 32'h0000_0200);
      expect_head_pc("resume_200", 32'h0000_0200);
      repeat (6) cycle(1'b0, 32'h0);
   endtask

   task automatic test_access_fault();
      do_reset(1'b0);
      lat = 1; tb_out_ready = 1'b1;
      err_addr = 32'h0000_0008;
      repeat (10) cycle(1'b0, 32'h0);
      n_cmp++;
      if (pops != 3 || m_out_valid !== 1'b0 || m_req_valid !== 1'b0) begin
         n_err++;
         $display("FAIL fault_halt: got pops %0d out_valid %b req_valid %b want 3 0 0",
                  pops, m_out_valid, m_req_valid);
      end
      cycle(1'b1, 32'h0000_0040);
      expect_head_pc("resume_40", 32'h0000_0040);
      repeat (6) cycle(1'b0, 32'h0);
   endtask

   task automatic test_wrap_redirect();
      do_reset(1'b1);
      lat = 1; tb_out_ready = 1'b1;
      repeat (6) cycle(1'b0, 32'h0);
      n_cmp++;
      if (m_req_valid !== 1'b1 || mq.size() == 0) begin
         n_err++;
         $display("FAIL collision_setup: got req_valid %b pending %0d want 1 and >0",
                  m_req_valid, mq.size());
      end
      cycle(1'b1, 32'h0000_0080);
      n_cmp++;
      if (m_out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL flush: got out_valid %b want 0", m_out_valid);
      end
      expect_head_pc("resume_80", 32'h0000_0080);
      repeat (6) cycle(1'b0, 32'h0);
   endtask

   initial begin
      n_cmp = 0; n_err = 0; lat = 1;
      tb_sel = 1'b0; rst0 = 1'b1; rstw = 1'b1;
      tb_redir = 1'b0; tb_redir_pc = 32'h0; tb_req_ready = 1'b1;
      tb_resp_valid = 1'b0; tb_resp_data = 32'h0; tb_resp_err = 1'b0; tb_out_ready = 1'b1;
      model_clear(32'h0);
      @(negedge clk);
      test_reset();
      test_back_to_back();
      test_backpressure();
      test_redirect_inflight();
      test_misaligned();
      test_access_fault();
      test_wrap_redirect();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
